// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB initiator turning single local commands into APB transfers
//
// Ports:
//   i_Pclk, i_Reset                     clock, asynchronous active-high reset
//   i_Cmd_Valid/Write/Addr/Wdata        local command, accepted when o_Cmd_Ready=1
//   o_Cmd_Ready, o_Busy                 idle / transfer-in-progress indicators
//   o_Rsp_Valid/Rdata/Err/Timeout       one-cycle response strobe and held status
//   o_Psel, o_Penable, o_Pwrite,        APB request side
//   o_Paddr, o_Pwdata
//   i_Pready, i_Prdata, i_Pslverr       APB completion side
module apb_requester #(
   parameter int ADDR_WIDTH     = 2,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  i_Pclk,
   input  logic                  i_Reset,
   input  logic                  i_Cmd_Valid,
   input  logic                  i_Cmd_Write,
   input  logic [ADDR_WIDTH-1:0] i_Cmd_Addr,
   input  logic [DATA_WIDTH-1:0] i_Cmd_Wdata,
   output logic                  o_Cmd_Ready,
   output logic                  o_Rsp_Valid,
   output logic [DATA_WIDTH-1:0] o_Rsp_Rdata,
   output logic                  o_Rsp_Err,
   output logic                  o_Rsp_Timeout,
   output logic                  o_Busy,
   output logic                  o_Psel,
   output logic                  o_Penable,
   output logic                  o_Pwrite,
   output logic [ADDR_WIDTH-1:0] o_Paddr,
   output logic [DATA_WIDTH-1:0] o_Pwdata,
   input  logic                  i_Pready,
   input  logic [DATA_WIDTH-1:0] i_Prdata,
   input  logic                  i_Pslverr
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CW-1:0] CNT_MAX = '1;
   // Counter value just before the final PREADY-low sample that triggers the abort.
   localparam logic [CW-1:0] TO_LAST = TIMEOUT_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t        state, next_state;
   logic          accept, complete, abort;
   logic [CW-1:0] wait_cnt;

   always_ff @(posedge i_Pclk or posedge i_Reset) begin
      if (i_Reset) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (i_Cmd_Valid) begin
               accept     = 1'b1;
               next_state = SETUP;
            end
         end
         SETUP: next_state = ACCESS;
         ACCESS: begin
            // A ready slave on the threshold edge still completes normally.
            if (i_Pready) begin
               complete   = 1'b1;
               next_state = IDLE;
            end else if (TIMEOUT_EN && wait_cnt == TO_LAST) begin
               abort      = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Bus controls decode straight from the state register so an asynchronous
   // reset drops PSEL/PENABLE immediately.
   assign o_Cmd_Ready = (state == IDLE);
   assign o_Busy      = (state != IDLE);
   assign o_Psel      = (state != IDLE);
   assign o_Penable   = (state == ACCESS);

   always_ff @(posedge i_Pclk or posedge i_Reset) begin
      if (i_Reset) begin
         o_Paddr       <= '0;
         o_Pwrite      <= 1'b0;
         o_Pwdata      <= '0;
         o_Rsp_Valid   <= 1'b0;
         o_Rsp_Rdata   <= '0;
         o_Rsp_Err     <= 1'b0;
         o_Rsp_Timeout <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         o_Rsp_Valid <= complete | abort;
         if (accept) begin
            o_Paddr  <= i_Cmd_Addr;
            o_Pwrite <= i_Cmd_Write;
            o_Pwdata <= i_Cmd_Wdata;
            wait_cnt <= '0;
         end else if (state == ACCESS && !i_Pready && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
         if (complete) begin
            o_Rsp_Rdata   <= o_Pwrite ? '0 : i_Prdata;
            o_Rsp_Err     <= i_Pslverr;
            o_Rsp_Timeout <= 1'b0;
         end else if (abort) begin
            o_Rsp_Rdata   <= '0;
            o_Rsp_Err     <= 1'b1;
            o_Rsp_Timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - self-checking bench for apb_requester
module tb_apb_requester;

   localparam int AW = 2;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pready, pslverr;
   logic [DW-1:0] prdata;

   int vectors = 0;
   int miscompares = 0;

   apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .i_Pclk(clk), .i_Reset(rst),
      .i_Cmd_Valid(cmd_valid), .i_Cmd_Write(cmd_write),
      .i_Cmd_Addr(cmd_addr), .i_Cmd_Wdata(cmd_wdata),
      .o_Cmd_Ready(cmd_ready), .o_Rsp_Valid(rsp_valid), .o_Rsp_Rdata(rsp_rdata),
      .o_Rsp_Err(rsp_err), .o_Rsp_Timeout(rsp_timeout), .o_Busy(busy),
      .o_Psel(psel), .o_Penable(penable), .o_Pwrite(pwrite),
      .o_Paddr(paddr), .o_Pwdata(pwdata),
      .i_Pready(pready), .i_Prdata(prdata), .i_Pslverr(pslverr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            waits;     // PREADY-low ACCESS cycles before PREADY rises
      logic [DW-1:0] rd;
      logic          slverr;
      int            exp_lat;   // cycles from accept edge to the response cycle
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
      logic          exp_to;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference model: a transfer times out once TO low samples are seen;
   // otherwise it completes after its wait states.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.exp_to    = (v.waits >= TO);
      r.exp_lat   = r.exp_to ? TO + 1 : v.waits + 2;
      r.exp_err   = r.exp_to | v.slverr;
      r.exp_rdata = (r.exp_to || v.write) ? '0 : v.rd;
      return r;
   endfunction

   task automatic do_txn(input vec_t v, input string tag);
      int k = 0, lat = -1, acc_cnt = 0, psel_cnt = 0, pen_cnt = 0, unstable = 0;
      logic [DW-1:0] got_rd = '0;
      logic got_err = 1'b0, got_to = 1'b0, got_psel = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
      check({tag, " cmd_ready"}, int'(cmd_ready), 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_wdata = 8'($urandom); cmd_addr = 2'($urandom);
      while (lat < 0 && k < 40) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = k; got_rd = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout; got_psel = psel;
         end else begin
            if (psel) begin
               psel_cnt++;
               if (paddr != v.addr || pwrite != v.write || (v.write && pwdata != v.wdata)) unstable++;
            end
            if (penable) begin
               pen_cnt++;
               if (acc_cnt == v.waits) begin
                  pready = 1'b1; pslverr = v.slverr; prdata = v.rd;
               end else begin
                  pready = 1'b0; pslverr = 1'($urandom); prdata = 8'($urandom);
               end
               acc_cnt++;
            end else begin
               pready = 1'($urandom); pslverr = 1'($urandom); prdata = 8'($urandom);
            end
            k++;
         end
      end
      check({tag, " latency"}, lat, v.exp_lat);
      check({tag, " rdata"}, int'(got_rd), int'(v.exp_rdata));
      check({tag, " err"}, int'(got_err), int'(v.exp_err));
      check({tag, " timeout"}, int'(got_to), int'(v.exp_to));
      check({tag, " psel_in_rsp"}, int'(got_psel), 0);
      check({tag, " psel_cycles"}, psel_cnt, v.exp_lat);
      check({tag, " penable_cycles"}, pen_cnt, v.exp_lat - 1);
      check({tag, " bus_stable"}, unstable, 0);
      @(negedge clk);
      check({tag, " rsp_pulse"}, int'(rsp_valid), 0);
      check({tag, " ready_after"}, int'(cmd_ready), 1);
   endtask

   vec_t tbl[7];

   initial begin
      vec_t v;
      int first, second, acc, pulses, adj, ready_busy;
      logic prev;

      tbl[0] = '{1'b1, 2'd1, 8'hA5, 0,  8'h00, 1'b0, 2,  8'h00, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 2'd2, 8'h00, 5,  8'h3C, 1'b0, 7,  8'h3C, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 2'd0, 8'h00, 99, 8'hEE, 1'b0, 17, 8'h00, 1'b1, 1'b1};
      tbl[3] = '{1'b0, 2'd3, 8'h00, 15, 8'h5A, 1'b0, 17, 8'h5A, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 2'd2, 8'h42, 0,  8'hFF, 1'b1, 2,  8'h00, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 2'd1, 8'h00, 0,  8'h77, 1'b0, 2,  8'h77, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 2'd3, 8'h00, 3,  8'h11, 1'b1, 5,  8'h11, 1'b1, 1'b0};

      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      #2;
      check("reset cmd_ready", int'(cmd_ready), 1);
      check("reset psel", int'(psel), 0);
      check("reset penable", int'(penable), 0);
      check("reset rsp_valid", int'(rsp_valid), 0);
      check("reset busy", int'(busy), 0);
      check("reset paddr", int'(paddr), 0);
      check("reset rsp_err", int'(rsp_err), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 25; i++) begin
         v = '{default: '0};
         v.write  = 1'($urandom);
         v.addr   = 2'($urandom);
         v.wdata  = 8'($urandom);
         v.waits  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
         v.rd     = 8'($urandom);
         v.slverr = 1'($urandom);
         do_txn(model(v), $sformatf("rnd%0d", i));
      end

      // Back-to-back: Cmd_Valid held high across two commands.
      pready = 1'b1; pslverr = 1'b0;
      first = -1; second = -1; acc = 0; pulses = 0; adj = 0; ready_busy = -1; prev = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_wdata = 8'h11;
      for (int t = 0; t < 12; t++) begin
         if (rsp_valid) begin pulses++; if (prev) adj++; end
         prev = rsp_valid;
         if (t == 1) ready_busy = int'(cmd_ready);
         if (cmd_valid && cmd_ready) begin
            if (acc == 0) first = t; else second = t;
            acc++;
         end
         @(posedge clk); #1;
         if (acc == 1) begin cmd_addr = 2'd1; cmd_wdata = 8'h22; end
         if (acc >= 2) cmd_valid = 1'b0;
         @(negedge clk);
      end
      check("b2b ready_while_busy", ready_busy, 0);
      check("b2b accept_spacing", second - first, 3);
      check("b2b pulses", pulses, 2);
      check("b2b adjacent", adj, 0);

      // Reset in the middle of a waiting ACCESS phase.
      pready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_mid penable_before", int'(penable), 1);
      rst = 1'b1;
      #1;
      check("rst_mid psel", int'(psel), 0);
      check("rst_mid penable", int'(penable), 0);
      check("rst_mid cmd_ready", int'(cmd_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      check("rst_mid no_rsp", pulses, 0);
      v = '{default: '0};
      v.write = 1'b0; v.addr = 2'd3; v.waits = 1; v.rd = 8'hC3;
      do_txn(model(v), "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/apb_requester.md
# apb_requester

APB initiator for the USRT peripheral bus: it turns single read and write commands from a local controller into APB setup and access phases on PSEL, PENABLE, PADDR, PWRITE and PWDATA. It waits on PREADY for any number of cycles, up to a programmable timeout, then returns read data and an error/timeout status through a one-cycle response strobe. It is the counterpart of the bus interface on the peripheral side; the two connect signal-for-signal.

## Interface
- ADDR_WIDTH, 2, width of PADDR and command address
- DATA_WIDTH, 8, width of PWDATA/PRDATA and command/response data
- TIMEOUT_CYCLES, 16, maximum access-phase cycles with PREADY low before abort; 0 disables the timeout
- i_Pclk  in  1  bus clock; all state changes on rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_Cmd_Valid  in  1  command request
- i_Cmd_Write  in  1  1 = write, 0 = read
- i_Cmd_Addr  in  ADDR_WIDTH  target address
- i_Cmd_Wdata  in  DATA_WIDTH  write data (ignored for reads)
- o_Cmd_Ready  out  1  command accepted on an edge where Valid and Ready are both 1
- o_Rsp_Valid  out  1  one-cycle response strobe
- o_Rsp_Rdata  out  DATA_WIDTH  read data, valid with o_Rsp_Valid
- o_Rsp_Err  out  1  PSLVERR was set at completion, or the transfer timed out
- o_Rsp_Timeout  out  1  the transfer was aborted by the timeout
- o_Busy  out  1  a transfer is in progress (SETUP or ACCESS)
- o_Psel, o_Penable, o_Pwrite  out  1  APB control
- o_Paddr  out  ADDR_WIDTH  APB address
- o_Pwdata  out  DATA_WIDTH  APB write data
- i_Pready  in  1  slave ready
- i_Prdata  in  DATA_WIDTH  slave read data
- i_Pslverr  in  1  slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS. The reset state is IDLE.
- o_Cmd_Ready = 1 only in IDLE. o_Busy = 1 in SETUP and ACCESS.
- IDLE, on an accepted command:
  - register Addr, Write and Wdata into o_Paddr, o_Pwrite and o_Pwdata.
  - go to SETUP.
- SETUP: o_Psel=1, o_Penable=0. Go to ACCESS unconditionally on the next edge.
- ACCESS: o_Psel=1, o_Penable=1. On each edge:
  - i_Pready=1: complete the transfer.
    - assert o_Rsp_Valid for one cycle.
    - o_Rsp_Err = i_Pslverr, o_Rsp_Timeout = 0.
    - for a read, o_Rsp_Rdata = i_Prdata; for a write, o_Rsp_Rdata = 0.
    - go to IDLE.
  - i_Pready=0: increment the wait counter. When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES ≠ 0), abort:
    - o_Rsp_Valid=1, o_Rsp_Err=1, o_Rsp_Timeout=1, o_Rsp_Rdata=0.
    - go to IDLE.
- Wait counter:
  - width is clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
  - cleared on entry to SETUP.
  - saturates and never wraps.
- o_Paddr, o_Pwrite and o_Pwdata are stable from SETUP through the completing edge. In IDLE they hold their last values.
- o_Rsp_Rdata, o_Rsp_Err and o_Rsp_Timeout hold their values until the next response.
- i_Pready, i_Prdata and i_Pslverr are sampled only in ACCESS; they are ignored in IDLE and SETUP.
- Only one outstanding transfer. A command presented while busy waits, because o_Cmd_Ready=0.

## Timing
- Reset value of every output is 0, except o_Cmd_Ready = 1 (IDLE). Reset takes effect immediately and asynchronously.
- Reset asserted mid-transfer: PSEL and PENABLE drop at once, no response is issued, and the FSM restarts in IDLE.
- Command accepted at edge N: SETUP (PSEL=1, PENABLE=0) after N, ACCESS after N+1.
- Zero-wait slave (PREADY=1 in the first ACCESS cycle): the transfer completes at edge N+2.
  - o_Rsp_Valid is high after N+2, in the same cycle that PSEL returns to 0.
  - o_Cmd_Ready returns to 1 after N+2. The next accept is at N+3 at the earliest, so the minimum period is 3 cycles per transfer.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- Timeout abort happens at the edge where the TIMEOUT_CYCLES-th consecutive PREADY-low sample is taken. PSEL/PENABLE are 0 and o_Rsp_Valid is 1 after that edge.
- PREADY=1 on the same edge as the timeout threshold: normal completion wins, and o_Rsp_Timeout=0.
- PSLVERR=1 with PREADY=0 is ignored. Only the value sampled at completion counts.
- o_Rsp_Valid is never high for two consecutive cycles.

## Test plan
- Write, zero wait: cmd Addr=1, Wdata=0xA5, write → PSEL high 2 cycles, PENABLE high 1 cycle, PADDR=1, PWRITE=1, PWDATA=0xA5 stable throughout; Rsp_Valid pulses 2 cycles after accept with Err=0.
- Read, 5 wait states: cmd Addr=2, read; PREADY low for 5 ACCESS cycles, then high with PRDATA=0x3C → Rsp_Valid pulses 7 cycles after accept, Rsp_Rdata=0x3C, Err=0, Timeout=0.
- Timeout (TIMEOUT_CYCLES=16): read with PREADY held low → abort 17 cycles after accept; PSEL=0, Rsp_Valid=1, Err=1, Timeout=1, Rdata=0. PREADY rising on the 16th ACCESS cycle → normal completion instead.
- Slave error: write with PREADY=1 and PSLVERR=1 in the first ACCESS cycle → Rsp_Err=1, Timeout=0. Read the same way with PSLVERR=0 → Err=0.
- Back-to-back: Cmd_Valid held high with two queued commands → Cmd_Ready low while busy; second accept 3 cycles after the first; two separate Rsp_Valid pulses, never adjacent.
- Reset mid-ACCESS: assert i_Reset while PREADY=0 → PSEL/PENABLE drop to 0 before the next edge, no Rsp_Valid, Cmd_Ready=1; a fresh command after reset completes normally.
